// File: rtl/div_result_display.sv
// Converts a quotient/remainder pair to two-digit BCD with an iterative double-dabble engine.
// Also scans the result QQRR onto a 4-digit active-low seven-segment display.
module div_result_display #(
    parameter int WIDTH    = 6,
    parameter int SCAN_DIV = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] r,
    output logic [7:0]       bcd_q,
    output logic [7:0]       bcd_r,
    output logic             bcd_valid,
    output logic [3:0]       an,
    output logic [6:0]       seg
);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_step;
    logic [WIDTH-1:0] r_bin_q;
    logic [WIDTH-1:0] r_bin_r;
    logic [7:0]       r_scr_q;
    logic [7:0]       r_scr_r;
    logic [7:0]       r_bcd_q;
    logic [7:0]       r_bcd_r;
    logic [7:0]       w_adj_q;
    logic [7:0]       w_adj_r;
    logic [7:0]       w_shift_q;
    logic [7:0]       w_shift_r;
    logic [SW-1:0]    r_scan_cnt;
    logic [1:0]       r_idx;
    logic [1:0]       w_idx_next;
    logic             w_wrap;
    logic [3:0]       w_digit;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;

    // Add-3 correction on each nibble independently, applied before every shift.
    function automatic logic [7:0] add3(input logic [7:0] v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = (v[7:4] >= 4'd5) ? v[7:4] + 4'd3 : v[7:4];
        lo = (v[3:0] >= 4'd5) ? v[3:0] + 4'd3 : v[3:0];
        return {hi, lo};
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign w_adj_q   = add3(r_scr_q);
    assign w_adj_r   = add3(r_scr_r);
    assign w_shift_q = {w_adj_q[6:0], r_bin_q[WIDTH-1]};
    assign w_shift_r = {w_adj_r[6:0], r_bin_r[WIDTH-1]};

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_next = CONV;
            CONV:    if (r_step == CW'(1)) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step  <= '0;
            r_bin_q <= '0;
            r_bin_r <= '0;
            r_scr_q <= 8'h00;
            r_scr_r <= 8'h00;
            r_bcd_q <= 8'h00;
            r_bcd_r <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_bin_q <= q;
                        r_bin_r <= r;
                        r_scr_q <= 8'h00;
                        r_scr_r <= 8'h00;
                        r_step  <= CW'(WIDTH);
                    end
                end
                CONV: begin
                    r_scr_q <= w_shift_q;
                    r_scr_r <= w_shift_r;
                    r_bin_q <= r_bin_q << 1;
                    r_bin_r <= r_bin_r << 1;
                    r_step  <= r_step - 1'b1;
                    // Final shift lands straight in the outputs; they never see partial sums.
                    if (r_step == CW'(1)) begin
                        r_bcd_q <= w_shift_q;
                        r_bcd_r <= w_shift_r;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_wrap     = (r_scan_cnt == SW'(SCAN_DIV - 1));
    assign w_idx_next = w_wrap ? r_idx + 2'd1 : r_idx;

    always_comb begin
        w_digit = r_bcd_r[3:0];
        case (w_idx_next)
            2'd0: w_digit = r_bcd_r[3:0];
            2'd1: w_digit = r_bcd_r[7:4];
            2'd2: w_digit = r_bcd_q[3:0];
            2'd3: w_digit = r_bcd_q[7:4];
            default: w_digit = r_bcd_r[3:0];
        endcase
    end

    // an/seg are decoded from the next index so they switch on the same edge as the index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_idx      <= 2'd0;
            r_an       <= 4'b1110;
            r_seg      <= 7'b1000000;
        end else begin
            r_scan_cnt <= w_wrap ? '0 : r_scan_cnt + 1'b1;
            r_idx      <= w_idx_next;
            r_an       <= ~(4'b0001 << w_idx_next);
            r_seg      <= seg_code(w_digit);
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign bcd_valid = (r_state == DONE);
    assign bcd_q     = r_bcd_q;
    assign bcd_r     = r_bcd_r;
    assign an        = r_an;
    assign seg       = r_seg;

endmodule

// File: doc/div_result_display.md
Name: div_result_display

Overview:
- Downstream stage of the combinational divider.
- Accepts a quotient/remainder pair through a valid/ready handshake and converts both to two-digit BCD with an iterative shift-add-3 (double-dabble) engine.
- Drives a time-multiplexed 4-digit active-low seven-segment display showing QQRR.
- Sits between div_top's q/r outputs and the board display pins.

Parameters:
- WIDTH, 6, operand width of q and r. Legal range 1..6, so values never exceed 63 and two BCD digits always suffice.
- SCAN_DIV, 16, clock cycles each display digit stays enabled before the scan advances. Must be >= 1.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream asserts when q/r are valid.
- in_ready  output  1  high when block can accept a pair.
- q  input  WIDTH  quotient from divider.
- r  input  WIDTH  remainder from divider.
- bcd_q  output  8  {tens,ones} BCD of last converted q.
- bcd_r  output  8  {tens,ones} BCD of last converted r.
- bcd_valid  output  1  one-cycle pulse when bcd_q/bcd_r update.
- an  output  4  active-low one-hot digit enable.
- seg  output  7  active-low segments; seg[6]=g … seg[0]=a.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state IDLE, so in_ready=1 (in_ready is decoded from state and reads 1 while rst_n is low). bcd_valid=0, bcd_q=8'h00, bcd_r=8'h00, scan index 0, scan counter 0, an=4'b1110, seg=7'b1000000 (digit 0).
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On a rising edge with in_valid=1: capture q and r into binary shift registers, clear the BCD scratch registers, load the step counter with WIDTH, go to CONV.
  - q and r are sampled only at this handshake edge.
- CONV:
  - in_ready=0.
  - Each edge, on both q and r paths in parallel:
    - every BCD scratch nibble >=5 gets +3;
    - then shift {bcd_scratch, bin} left by 1;
    - decrement the counter.
  - On the edge where the counter reaches 0: load bcd_q/bcd_r from scratch and go to DONE.
- DONE:
  - in_ready=0, bcd_valid=1 for exactly this cycle.
  - Next edge returns to IDLE.
- Latency and throughput:
  - Handshake at edge E0. Outputs update and bcd_valid rises at edge E(WIDTH); falls at E(WIDTH+1).
  - in_ready is low for WIDTH+1 cycles.
  - Back-to-back transfers: with in_valid held high, the next pair is accepted at E(WIDTH+1). Throughput is one pair per WIDTH+1 cycles.
- in_valid while in_ready=0: ignored, nothing captured. Upstream must hold data until in_ready=1.
- bcd_q/bcd_r hold their value between conversions. They never show partial results.
- Scan logic:
  - Free-running, independent of the FSM.
  - The counter counts 0..SCAN_DIV-1. On wrap, the digit index advances 0→1→2→3→0.
  - Index to digit mapping:
    - 0: an=1110, bcd_r ones.
    - 1: an=1101, bcd_r tens.
    - 2: an=1011, bcd_q ones.
    - 3: an=0111, bcd_q tens.
  - an and seg are registered, so they change on the same edge.
  - Leading zeros are displayed, not blanked.
  - A nibble >9 (unreachable) shows blank, seg=7'b1111111.
- Segment codes (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Reset mid-operation: asserting rst_n at any time forces all reset values asynchronously. An in-progress conversion is discarded and no bcd_valid is produced. in_valid is ignored until rst_n is high at a clock edge.
- Width rule: the BCD scratch is 8 bits per operand. Add-3 correction is applied to each nibble independently before every shift, including the first.

Test Plan:
1. Reset: hold rst_n=0 mid-scan → in_ready=1, bcd_valid=0, bcd_q=bcd_r=8'h00, an=1110, seg=1000000 immediately (asynchronously).
2. q=7, r=3, in_valid pulsed one cycle → bcd_valid high exactly 6 cycles after the handshake edge for one cycle, bcd_q=8'h07, bcd_r=8'h03; in_ready low 7 cycles.
3. Boundaries:
   - q=63, r=62 → 8'h63/8'h62;
   - q=10, r=9 → 8'h10/8'h09;
   - q=0, r=0 → 8'h00/8'h00.
   - Also compare all 64×64 pairs against a reference model.
4. Hold in_valid=1 and change q/r during CONV → changed data ignored; the second pair is accepted exactly at the edge with in_ready=1 (7 cycles after the first handshake) and converts correctly.
5. SCAN_DIV=4, load q=42, r=17 → an steps 1110,1101,1011,0111 every 4 cycles. seg shows 1111000 (7), 1111001 (1), 0100100 (2), 0011001 (4), then wraps.
6. Assert rst_n=0 three cycles into a conversion of q=55 → no bcd_valid, outputs return to 8'h00. After release, a new pair q=12, r=5 converts to 8'h12/8'h05 with normal latency.
